// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with one-entry skid buffer.
// Registered handshake, flush discards with a saturating discard count.
module if_id_skid_stage #(
  parameter int unsigned       INST_W   = 8,
  parameter int unsigned       PC_W     = 8,
  parameter logic [INST_W-1:0] NOP_INST = '0,
  parameter int unsigned       CNT_W    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_discards
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [INST_W-1:0]   head_inst_q, head_inst_d;
  logic [PC_W-1:0]     head_pc_q, head_pc_d;
  logic [INST_W-1:0]   skid_inst_q, skid_inst_d;
  logic [PC_W-1:0]     skid_pc_q, skid_pc_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                xfer;
  logic                pop;
  logic [1:0]          dec;
  logic [CNT_W:0]      sum;

  assign xfer = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // Entries lost to a flush: held ones minus the one decode took.
  assign dec = state_q - {1'b0, pop};
  assign sum = {1'b0, cnt_q} + (CNT_W+1)'(dec);

  always_comb begin
    state_d     = state_q;
    head_inst_d = head_inst_q;
    head_pc_d   = head_pc_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    cnt_d       = cnt_q;

    if (flush) begin
      state_d = EMPTY;
      if (sum[CNT_W]) cnt_d = '1;
      else            cnt_d = sum[CNT_W-1:0];
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (xfer) begin
            state_d     = ONE;
            head_inst_d = in_inst;
            head_pc_d   = in_pc;
          end
        end
        ONE: begin
          if (xfer && !pop) begin
            state_d     = FULL;
            skid_inst_d = in_inst;
            skid_pc_d   = in_pc;
          end else if (!xfer && pop) begin
            state_d = EMPTY;
          end else if (xfer && pop) begin
            head_inst_d = in_inst;
            head_pc_d   = in_pc;
          end
        end
        FULL: begin
          if (pop) begin
            state_d     = ONE;
            head_inst_d = skid_inst_q;
            head_pc_d   = skid_pc_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    if (state_d == EMPTY) begin
      head_inst_d = NOP_INST;
      head_pc_d   = '0;
      skid_inst_d = '0;
      skid_pc_d   = '0;
    end

    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= EMPTY;
      head_inst_q <= NOP_INST;
      head_pc_q   <= '0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      head_inst_q <= head_inst_d;
      head_pc_q   <= head_pc_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_inst       = head_inst_q;
  assign out_pc         = head_pc_q;
  assign occupancy      = state_q;
  assign flush_discards = cnt_q;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: queue model, directed cases, random run.
// A second instance with a 2-bit counter covers saturation.
module tb_if_id_skid_stage;

  localparam int CW   = 16;
  localparam int MAXC = (1 << CW) - 1;

  logic        clock;
  logic        reset;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [7:0]  in_inst, in_pc, out_inst, out_pc;
  logic [1:0]  occupancy;
  logic [CW-1:0] flush_discards;

  logic        s_valid, s_ready, s_flush, s_ovalid, s_oready;
  logic [7:0]  s_inst, s_pc, s_oinst, s_opc;
  logic [1:0]  s_occ;
  logic [1:0]  s_fd;

  int n_run  = 0;
  int n_fail = 0;
  bit chk_on = 0;

  if_id_skid_stage #(.CNT_W(CW)) u_dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc),
    .occupancy(occupancy), .flush_discards(flush_discards)
  );

  if_id_skid_stage #(.CNT_W(2)) u_sat (
    .clock(clock), .reset(reset),
    .in_valid(s_valid), .in_ready(s_ready),
    .in_inst(s_inst), .in_pc(s_pc),
    .flush(s_flush),
    .out_valid(s_ovalid), .out_ready(s_oready),
    .out_inst(s_oinst), .out_pc(s_opc),
    .occupancy(s_occ), .flush_discards(s_fd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: a FIFO of at most two {inst,pc} entries.
  logic [15:0] mq[$];
  bit          m_rdy;
  int          m_cnt;
  int          m_sz;
  bit          m_pop, m_xfer;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_rdy = 1'b0;
      m_cnt = 0;
    end else begin
      m_sz   = mq.size();
      m_pop  = (m_sz > 0) && out_ready;
      m_xfer = in_valid && m_rdy;
      if (flush) begin
        m_cnt = m_cnt + m_sz - int'(m_pop);
        if (m_cnt > MAXC) m_cnt = MAXC;
        mq.delete();
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_xfer) mq.push_back({in_inst, in_pc});
      end
      m_rdy = (mq.size() < 2);
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [7:0] e_inst, e_pc;
  bit         e_ov;

  always @(negedge clock) begin
    if (chk_on) begin
      e_ov   = (mq.size() > 0);
      e_inst = e_ov ? mq[0][15:8] : 8'h00;
      e_pc   = e_ov ? mq[0][7:0]  : 8'h00;
      chk("cyc_ctl", {28'd0, out_valid, in_ready, occupancy},
          {28'd0, e_ov, m_rdy, 2'(mq.size())});
      chk("cyc_data", {out_inst, out_pc, flush_discards},
          {e_inst, e_pc, 16'(m_cnt)});
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic lit(string nm, logic [7:0] ei, logic [7:0] ep,
                     logic [1:0] eo, logic er);
    chk({nm, "_inst"}, {24'd0, out_inst}, {24'd0, ei});
    chk({nm, "_pc"}, {24'd0, out_pc}, {24'd0, ep});
    chk({nm, "_occ"}, {30'd0, occupancy}, {30'd0, eo});
    chk({nm, "_rdy"}, {31'd0, in_ready}, {31'd0, er});
  endtask

  task automatic offer(logic v, logic [7:0] i, logic [7:0] p);
    in_valid = v;
    in_inst  = i;
    in_pc    = p;
  endtask

  logic [1:0] sat_exp[6];

  initial begin
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    reset = 1'b1;
    offer(0, 8'h00, 8'h00);
    flush = 0; out_ready = 0;
    s_valid = 0; s_inst = 8'h00; s_pc = 8'h00;
    s_flush = 0; s_oready = 0;
    #1 reset = 1'b0;
    #20;
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clock);
    reset  = 1'b1;
    chk_on = 1;
    cyc();
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Streaming at full rate.
    out_ready = 1;
    offer(1, 8'h11, 8'h00); cyc(); lit("s1", 8'h11, 8'h00, 2'd1, 1);
    offer(1, 8'h22, 8'h01); cyc(); lit("s2", 8'h22, 8'h01, 2'd1, 1);
    offer(1, 8'h33, 8'h02); cyc(); lit("s3", 8'h33, 8'h02, 2'd1, 1);
    offer(0, 8'h00, 8'h00); cyc(); lit("s4", 8'h00, 8'h00, 2'd0, 1);

    // Backpressure fills the skid slot.
    out_ready = 0;
    offer(1, 8'hA1, 8'h10); cyc(); lit("b1", 8'hA1, 8'h10, 2'd1, 1);
    offer(1, 8'hA2, 8'h11); cyc(); lit("b2", 8'hA1, 8'h10, 2'd2, 0);
    offer(1, 8'hA3, 8'h12); cyc(); lit("b3", 8'hA1, 8'h10, 2'd2, 0);
    out_ready = 1;          cyc(); lit("b4", 8'hA2, 8'h11, 2'd1, 1);
                            cyc(); lit("b5", 8'hA3, 8'h12, 2'd1, 1);
    offer(0, 8'h00, 8'h00); cyc(); lit("b6", 8'h00, 8'h00, 2'd0, 1);

    // Flush while full with a coincident offer.
    out_ready = 0;
    offer(1, 8'hB1, 8'h20); cyc();
    offer(1, 8'hB2, 8'h21); cyc(); lit("f0", 8'hB1, 8'h20, 2'd2, 0);
    flush = 1;
    offer(1, 8'hB3, 8'h22); cyc();
    flush = 0;
    offer(0, 8'h00, 8'h00);
    lit("f1", 8'h00, 8'h00, 2'd0, 1);
    chk("f1_valid", {31'd0, out_valid}, 32'd0);
    chk("f1_disc", {16'd0, flush_discards}, 32'd2);
    cyc();
    chk("f2_occ", {30'd0, occupancy}, 32'd0);

    // Asynchronous reset while full.
    offer(1, 8'hC1, 8'h30); cyc();
    offer(1, 8'hC2, 8'h31); cyc();
    offer(0, 8'h00, 8'h00);
    chk("ar_pre_occ", {30'd0, occupancy}, 32'd2);
    #2 reset = 1'b0;
    #1;
    lit("ar", 8'h00, 8'h00, 2'd0, 0);
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_disc", {16'd0, flush_discards}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    cyc();
    chk("ar_ready", {31'd0, in_ready}, 32'd1);

    // Saturation on the 2-bit counter instance.
    for (int k = 0; k < 6; k++) begin
      s_valid = 1; s_inst = 8'(k); s_pc = 8'(k);
      cyc();
      s_valid = 0; s_flush = 1;
      cyc();
      s_flush = 0;
      chk($sformatf("sat%0d", k), {30'd0, s_fd}, {30'd0, sat_exp[k]});
    end

    // Randomised run against the queue model.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_inst   = 8'($urandom);
      in_pc     = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      cyc();
      if (occupancy > 2'd2) chk("occ_max", {30'd0, occupancy}, 32'd2);
    end
    flush = 0; in_valid = 0; out_ready = 0;
    cyc();
    chk("rand_disc", {16'd0, flush_discards}, m_cnt);
    @(negedge clock);
    chk_on = 0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_skid_stage.md
IF_ID_SKID_STAGE -- requirements
Module: if_id_skid_stage

Interface
REQ-001 Parameter INST_W, default 8, SHALL set instruction width in bits (legal 8..64).
REQ-002 Parameter PC_W, default 8, SHALL set program-counter width in bits (legal 4..32).
REQ-003 Parameter NOP_INST, default all-zero INST_W bits, SHALL be the instruction value driven whenever the stage holds no valid entry.
REQ-004 Parameter CNT_W, default 8, SHALL set the flush-discard counter width.
REQ-005 clock  input  1  SHALL be the rising-edge clock for all state.
REQ-006 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-007 in_valid  input  1  SHALL indicate the fetch side offers an entry.
REQ-008 in_ready  output  1  SHALL indicate the stage accepts an entry; a transfer occurs when in_valid and in_ready are both 1 at a rising edge.
REQ-009 in_inst  input  INST_W  SHALL carry the offered instruction.
REQ-010 in_pc  input  PC_W  SHALL carry the offered program counter.
REQ-011 flush  input  1  SHALL be the synchronous discard request from the decode/branch logic.
REQ-012 out_valid  output  1  SHALL indicate out_inst/out_pc hold a valid entry.
REQ-013 out_ready  input  1  SHALL indicate decode consumes the entry; a pop occurs when out_valid and out_ready are both 1 at a rising edge.
REQ-014 out_inst  output  INST_W  SHALL present the head instruction.
REQ-015 out_pc  output  PC_W  SHALL present the head program counter.
REQ-016 occupancy  output  2  SHALL report entries held: 0, 1 or 2.
REQ-017 flush_discards  output  CNT_W  SHALL count entries discarded by flush.

Function
REQ-018 Storage SHALL be a head register (drives outputs) plus one skid register; all outputs SHALL be driven directly from flops.
REQ-019 State SHALL be EMPTY (occ 0), ONE (occ 1), FULL (occ 2); occupancy SHALL equal the state encoding.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, registered (no combinational path from out_ready or flush).
REQ-021 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-022 EMPTY: transfer -> ONE, head <= input, output visible the next cycle (latency 1); no transfer -> stay.
REQ-023 ONE: transfer without pop -> FULL, skid <= input; pop without transfer -> EMPTY; transfer with pop -> ONE, head <= input; neither -> stay, head held.
REQ-024 FULL: pop -> ONE, head <= skid; no pop -> stay, head and skid held; in_valid ignored.
REQ-025 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or dropped except by flush.
REQ-026 Whenever the next state is EMPTY, out_inst SHALL become NOP_INST and out_pc SHALL become 0.
REQ-027 flush=1 SHALL take priority over transfer and pop: next state EMPTY, head and skid invalidated, out_inst <= NOP_INST, out_pc <= 0, in_ready <= 1; any transfer coincident with flush SHALL be discarded; a coincident pop SHALL count as performed by decode, but the stage is emptied regardless.
REQ-028 On flush, flush_discards SHALL increase by the number of entries held before the edge (0, 1 or 2) minus 1 if a pop coincided, saturating at 2^CNT_W-1, never wrapping.
REQ-029 flush held high for multiple cycles SHALL keep the stage EMPTY; no additional counts SHALL accrue while EMPTY.

Reset
REQ-030 reset=0 SHALL asynchronously force state EMPTY, out_valid=0, in_ready=0, out_inst=NOP_INST, out_pc=0, skid cleared, occupancy=0, flush_discards=0.
REQ-031 in_ready SHALL rise to 1 at the first rising edge after reset deasserts; reset asserted mid-operation SHALL discard all entries without counting them.

Verification
REQ-032 Reset, then in_valid=1 with inst 0x11/pc 0x00, 0x22/0x01, 0x33/0x02 on consecutive cycles, out_ready=1 -> out_inst 0x11, 0x22, 0x33 one cycle after each acceptance, occupancy stays 1, in_ready stays 1.
REQ-033 out_ready=0, offer 0xA1, 0xA2, 0xA3 -> 0xA1 and 0xA2 accepted, occupancy 2, in_ready=0, 0xA3 held off; set out_ready=1 -> pops 0xA1, 0xA2, then 0xA3 accepted and popped, with no loss or reordering.
REQ-034 FULL (occupancy 2), flush=1 for one cycle with in_valid=1 -> next cycle occupancy 0, out_valid=0, out_inst=NOP_INST, out_pc=0, flush_discards=2, offered entry not stored.
REQ-035 CNT_W=2, six flushes each with occupancy 1 and no pop -> flush_discards reads 1, 2, 3, 3, 3, 3.
REQ-036 Assert reset while occupancy is 2 -> all outputs return to reset values immediately without waiting for a clock edge; flush_discards=0; in_ready=1 one edge after release.
REQ-037 Randomised in_valid/out_ready/flush against a scoreboard for 10,000 cycles -> in-order delivery, occupancy never above 2, flush_discards equal to the scoreboard discard count.
